// File: rtl/game_pkg.sv
// Shared types for the volleyball game-flow sequencer: FSM states, side and
// winner encodings, and the default score width.
package game_pkg;

   localparam int SCORE_W = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      RALLY = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam logic SIDE_P1 = 1'b0;
   localparam logic SIDE_P2 = 1'b1;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10
   } win_t;

endpackage

// File: rtl/match_ctrl_if.sv
// Signal bundle between the game-flow sequencer (master) and the frame source,
// buttons and physics block around it (slave).
interface match_ctrl_if #(
   parameter int SCORE_W = game_pkg::SCORE_W
);
   logic               frame_tick;
   logic               start_btn;
   logic               point_evt;
   logic [SCORE_W-1:0] p1_score;
   logic [SCORE_W-1:0] p2_score;
   logic               p1_cover;
   logic               p2_cover;
   logic               phys_step;
   logic               match_clr_n;
   logic               fault_p1;
   logic               fault_p2;
   logic               serve_side;
   logic [1:0]         winner;
   logic [2:0]         state;
   logic [7:0]         rally_len;

   modport master (
      input  frame_tick, start_btn, point_evt, p1_score, p2_score, p1_cover, p2_cover,
      output phys_step, match_clr_n, fault_p1, fault_p2, serve_side, winner, state, rally_len
   );

   modport slave (
      output frame_tick, start_btn, point_evt, p1_score, p2_score, p1_cover, p2_cover,
      input  phys_step, match_clr_n, fault_p1, fault_p2, serve_side, winner, state, rally_len
   );
endinterface

// File: rtl/rise_detect.sv
// One-bit rising-edge detector; the previous value resets to 1 so an input
// already high when reset is released never reports an edge.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);
   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev <= 1'b1;
      else        prev <= d;
   end

   assign rise = d & ~prev;
endmodule

// File: rtl/match_ctrl.sv
// Game-flow sequencer: gates the physics step per frame, holds the ball for
// serve and after points, enforces the touch limit and detects match end.
module match_ctrl #(
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_FRAMES = 30,
   parameter int PAUSE_FRAMES = 60,
   parameter int MAX_TOUCHES  = 3,
   parameter int SCORE_W      = game_pkg::SCORE_W
) (
   input logic          clk,
   input logic          rst_n,
   match_ctrl_if.master bus
);
   import game_pkg::*;

   logic start_rise, p1_rise, p2_rise;

   rise_detect u_start (.clk(clk), .rst_n(rst_n), .d(bus.start_btn), .rise(start_rise));
   rise_detect u_p1    (.clk(clk), .rst_n(rst_n), .d(bus.p1_cover),  .rise(p1_rise));
   rise_detect u_p2    (.clk(clk), .rst_n(rst_n), .d(bus.p2_cover),  .rise(p2_rise));

   state_t             st;
   logic               entry;
   logic [7:0]         fcnt;
   logic [2:0]         cnt_p1, cnt_p2;
   logic               last_side;
   logic [SCORE_W-1:0] base_p1, base_p2;
   logic               fault_cause, fault_side;
   logic               clr_n, flt_p1, flt_p2, srv;
   win_t               win;
   logic [7:0]         rlen;

   logic       t1, t2, f1, f2;
   logic [2:0] n1, n2;

   // A simultaneous contact by both players is credited to P1 alone.
   always_comb begin
      t1 = p1_rise;
      t2 = p2_rise & ~p1_rise;
      n1 = (last_side == SIDE_P1) ? cnt_p1 + 3'd1 : 3'd1;
      n2 = (last_side == SIDE_P2) ? cnt_p2 + 3'd1 : 3'd1;
      f1 = t1 && (n1 == 3'(MAX_TOUCHES + 1));
      f2 = t2 && (n2 == 3'(MAX_TOUCHES + 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st          <= IDLE;
         entry       <= 1'b0;
         fcnt        <= 8'd0;
         cnt_p1      <= 3'd0;
         cnt_p2      <= 3'd0;
         last_side   <= SIDE_P1;
         base_p1     <= '0;
         base_p2     <= '0;
         fault_cause <= 1'b0;
         fault_side  <= SIDE_P1;
         clr_n       <= 1'b1;
         flt_p1      <= 1'b0;
         flt_p2      <= 1'b0;
         srv         <= SIDE_P2;
         win         <= WIN_NONE;
         rlen        <= 8'd0;
      end else begin
         clr_n  <= 1'b1;
         flt_p1 <= 1'b0;
         flt_p2 <= 1'b0;
         entry  <= 1'b0;
         if (bus.frame_tick && !entry && (st == SERVE || st == POINT))
            fcnt <= fcnt + 8'd1;
         case (st)
            IDLE: begin
               if (start_rise) begin
                  clr_n <= 1'b0;
                  srv   <= SIDE_P2;
                  st    <= SERVE;
                  entry <= 1'b1;
                  fcnt  <= 8'd0;
               end
            end
            SERVE: begin
               cnt_p1    <= 3'd0;
               cnt_p2    <= 3'd0;
               last_side <= SIDE_P1;
               rlen      <= 8'd0;
               // Scores are frozen outside a rally; the scorer is whoever moved off this base.
               base_p1   <= bus.p1_score;
               base_p2   <= bus.p2_score;
               if (fcnt == 8'(SERVE_FRAMES)) begin
                  st    <= RALLY;
                  entry <= 1'b1;
                  fcnt  <= 8'd0;
               end
            end
            RALLY: begin
               if (t1) begin
                  cnt_p1    <= n1;
                  last_side <= SIDE_P1;
               end else if (t2) begin
                  cnt_p2    <= n2;
                  last_side <= SIDE_P2;
               end
               if ((t1 || t2) && rlen != 8'hFF) rlen <= rlen + 8'd1;
               if (bus.point_evt) begin
                  fault_cause <= 1'b0;
                  st          <= POINT;
                  entry       <= 1'b1;
                  fcnt        <= 8'd0;
               end else if (f1 || f2) begin
                  flt_p1      <= f1;
                  flt_p2      <= f2;
                  fault_cause <= 1'b1;
                  fault_side  <= f1 ? SIDE_P1 : SIDE_P2;
                  st          <= POINT;
                  entry       <= 1'b1;
                  fcnt        <= 8'd0;
               end
            end
            POINT: begin
               // Sampled at the end of the entry cycle so the physics scores have settled.
               if (entry)
                  srv <= fault_cause ? ~fault_side
                                     : ((bus.p2_score != base_p2) ? SIDE_P2 : SIDE_P1);
               if (fcnt == 8'(PAUSE_FRAMES)) begin
                  entry <= 1'b1;
                  fcnt  <= 8'd0;
                  if (bus.p1_score >= SCORE_W'(WIN_SCORE)) begin
                     win <= WIN_P1;
                     st  <= OVER;
                  end else if (bus.p2_score >= SCORE_W'(WIN_SCORE)) begin
                     win <= WIN_P2;
                     st  <= OVER;
                  end else begin
                     st  <= SERVE;
                  end
               end
            end
            OVER: begin
               if (start_rise) begin
                  clr_n <= 1'b0;
                  win   <= WIN_NONE;
                  srv   <= SIDE_P2;
                  st    <= SERVE;
                  entry <= 1'b1;
                  fcnt  <= 8'd0;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

   assign bus.phys_step   = (st == RALLY) & bus.frame_tick;
   assign bus.match_clr_n = clr_n;
   assign bus.fault_p1    = flt_p1;
   assign bus.fault_p2    = flt_p2;
   assign bus.serve_side  = srv;
   assign bus.winner      = win;
   assign bus.state       = st;
   assign bus.rally_len   = rlen;
endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: directed match flow plus randomized rallies checked
// against a touch-history model of the touch rule and a score model.
module tb_match_ctrl;
   import game_pkg::*;

   localparam int SERVE_F = 30;
   localparam int PAUSE_F = 60;
   localparam int WIN_S   = 7;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   match_ctrl_if #(.SCORE_W(4)) bus ();

   match_ctrl #(
      .WIN_SCORE(WIN_S), .SERVE_FRAMES(SERVE_F), .PAUSE_FRAMES(PAUSE_F),
      .MAX_TOUCHES(3), .SCORE_W(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   logic side_q[$];
   int   m_p1 = 0;
   int   m_p2 = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n, input logic exp_step);
      for (int i = 0; i < n; i++) begin
         bus.frame_tick = 1'b1;
         #1;
         check("phys_step", bus.phys_step, exp_step);
         step();
         bus.frame_tick = 1'b0;
         step();
      end
   endtask

   task automatic begin_rally();
      step();
      frames(SERVE_F - 1, 1'b0);
      check("serve_hold", bus.state, SERVE);
      frames(1, 1'b0);
      check("rally_entry", bus.state, RALLY);
      frames(1, 1'b1);
      side_q.delete();
   endtask

   // Model: a fault is a run of four consecutive touches by the same side.
   task automatic touch(input logic [1:0] mask, output logic faulted);
      logic side, other;
      int run, len;
      side  = mask[0] ? SIDE_P1 : SIDE_P2;
      other = ~side;
      side_q.push_back(side);
      run = 0;
      for (int i = side_q.size() - 1; i >= 0; i--) begin
         if (side_q[i] != side) break;
         run++;
      end
      faulted = (run == 4);
      len = (side_q.size() > 255) ? 255 : side_q.size();
      bus.p1_cover = mask[0];
      bus.p2_cover = mask[1];
      step();
      check("fault_p1", bus.fault_p1, faulted && (side == SIDE_P1));
      check("fault_p2", bus.fault_p2, faulted && (side == SIDE_P2));
      check("rally_len", bus.rally_len, len);
      check("touch_state", bus.state, faulted ? POINT : RALLY);
      bus.p1_cover = 1'b0;
      bus.p2_cover = 1'b0;
      step();
      if (faulted) check("serve_fault", bus.serve_side, other);
   endtask

   task automatic score_point(input logic side);
      if (side == SIDE_P1) m_p1++;
      else                 m_p2++;
      bus.p1_score  = 4'(m_p1);
      bus.p2_score  = 4'(m_p2);
      bus.point_evt = 1'b1;
      step();
      check("point_state", bus.state, POINT);
      bus.point_evt = 1'b0;
      step();
      check("serve_point", bus.serve_side, side);
   endtask

   task automatic end_point();
      frames(PAUSE_F - 1, 1'b0);
      check("pause_hold", bus.state, POINT);
      frames(1, 1'b0);
      if (m_p1 >= WIN_S || m_p2 >= WIN_S) begin
         check("over_state", bus.state, OVER);
         check("winner", bus.winner, (m_p1 >= WIN_S) ? 2'b01 : 2'b10);
      end else begin
         check("next_serve", bus.state, SERVE);
         check("winner_none", bus.winner, 2'b00);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       flt;
      logic [1:0] mask;
      logic       pick;
      int         sel;

      rst_n          = 1'b0;
      bus.frame_tick = 1'b0;
      bus.start_btn  = 1'b0;
      bus.point_evt  = 1'b0;
      bus.p1_score   = 4'd0;
      bus.p2_score   = 4'd0;
      bus.p1_cover   = 1'b0;
      bus.p2_cover   = 1'b0;
      step();
      step();
      check("rst_state", bus.state, IDLE);
      check("rst_step", bus.phys_step, 1'b0);
      check("rst_clr", bus.match_clr_n, 1'b1);
      check("rst_f1", bus.fault_p1, 1'b0);
      check("rst_f2", bus.fault_p2, 1'b0);
      check("rst_serve", bus.serve_side, 1'b1);
      check("rst_winner", bus.winner, 2'b00);
      check("rst_rlen", bus.rally_len, 8'd0);
      rst_n = 1'b1;
      step();

      // Start of match
      bus.start_btn = 1'b1;
      step();
      check("start_state", bus.state, SERVE);
      check("start_clr", bus.match_clr_n, 1'b0);
      step();
      check("clr_release", bus.match_clr_n, 1'b1);
      bus.start_btn = 1'b0;
      begin_rally();
      frames(2, 1'b1);
      score_point(SIDE_P1);
      end_point();
      begin_rally();
      score_point(SIDE_P2);
      end_point();

      // Four P1 touches in a row
      begin_rally();
      for (int i = 0; i < 4; i++) touch(2'b01, flt);
      end_point();

      // P2 touch breaks the P1 run
      begin_rally();
      for (int i = 0; i < 3; i++) touch(2'b01, flt);
      touch(2'b10, flt);
      touch(2'b01, flt);
      score_point(SIDE_P2);
      end_point();

      // Simultaneous contacts credit P1 only
      begin_rally();
      for (int i = 0; i < 3; i++) touch(2'b11, flt);
      touch(2'b01, flt);
      end_point();

      // Fault edge coinciding with a point: the point wins, no fault pulse
      begin_rally();
      for (int i = 0; i < 3; i++) touch(2'b01, flt);
      m_p2++;
      bus.p2_score  = 4'(m_p2);
      bus.p1_cover  = 1'b1;
      bus.point_evt = 1'b1;
      step();
      check("prio_state", bus.state, POINT);
      check("prio_f1", bus.fault_p1, 1'b0);
      check("prio_f2", bus.fault_p2, 1'b0);
      bus.p1_cover  = 1'b0;
      bus.point_evt = 1'b0;
      step();
      check("prio_serve", bus.serve_side, SIDE_P2);
      end_point();

      // Randomized rallies
      for (int r = 0; r < 4; r++) begin
         begin_rally();
         flt = 1'b0;
         for (int k = 0; k < 10 && !flt; k++) begin
            sel  = $urandom_range(0, 4);
            mask = (sel <= 2) ? 2'b01 : (sel == 3) ? 2'b10 : 2'b11;
            touch(mask, flt);
         end
         if (!flt) begin
            pick = 1'($urandom_range(0, 1));
            if (pick == SIDE_P1 && m_p1 >= 5)      pick = SIDE_P2;
            else if (pick == SIDE_P2 && m_p2 >= 5) pick = SIDE_P1;
            score_point(pick);
         end
         end_point();
      end

      // Match end with P1 reaching the winning score
      m_p1 = WIN_S - 1;
      bus.p1_score = 4'(m_p1);
      begin_rally();
      score_point(SIDE_P1);
      end_point();
      frames(3, 1'b0);
      check("over_hold", bus.state, OVER);
      check("winner_hold", bus.winner, 2'b01);
      bus.start_btn = 1'b1;
      step();
      check("restart_state", bus.state, SERVE);
      check("restart_winner", bus.winner, 2'b00);
      check("restart_clr", bus.match_clr_n, 1'b0);
      check("restart_serve", bus.serve_side, 1'b1);
      bus.start_btn = 1'b0;
      m_p1 = 0;
      m_p2 = 0;
      bus.p1_score = 4'd0;
      bus.p2_score = 4'd0;

      // Asynchronous reset in the middle of a rally
      begin_rally();
      touch(2'b01, flt);
      bus.frame_tick = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_state", bus.state, IDLE);
      check("arst_step", bus.phys_step, 1'b0);
      check("arst_rlen", bus.rally_len, 8'd0);
      check("arst_serve", bus.serve_side, 1'b1);
      check("arst_winner", bus.winner, 2'b00);
      check("arst_clr", bus.match_clr_n, 1'b1);
      bus.frame_tick = 1'b0;
      bus.start_btn  = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      step();
      step();
      step();
      check("held_start", bus.state, IDLE);
      bus.start_btn = 1'b0;
      step();
      check("start_fall", bus.state, IDLE);
      bus.start_btn = 1'b1;
      step();
      check("start_again", bus.state, SERVE);
      bus.start_btn = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/match_ctrl.md
# match_ctrl

Game-flow sequencer for the volleyball physics datapath. It gates the per-frame physics step, holds the ball during serve and after each point, and enforces the three-touch rule from player/ball contact. It detects match end from the physics scores. It sits between the frame-timing source (VGA vsync tick) and the physics block, and drives the physics step enable and the match clear.

## Interface

Parameters:
- WIN_SCORE, 7: score at which a match ends (≤ 15).
- SERVE_FRAMES, 30: frames the ball is held before a rally.
- PAUSE_FRAMES, 60: frames of freeze after a point.
- MAX_TOUCHES, 3: legal consecutive touches per side.
- SCORE_W, 4: score width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start_btn  in  1  start/restart level, already synchronized.
- point_evt  in  1  physics `game_over` pulse (point scored).
- p1_score, p2_score  in  SCORE_W  physics scores.
- p1_cover, p2_cover  in  1  player–ball overlap levels.
- phys_step  out  1  physics clock enable.
- match_clr_n  out  1  active-low one-cycle clear to physics, for scores and ball.
- fault_p1, fault_p2  out  1  one-cycle four-touch fault pulses.
- serve_side  out  1  0 = P1, 1 = P2.
- winner  out  2  00 none, 01 P1, 10 P2.
- state  out  3  current FSM state.
- rally_len  out  8  touches in the current rally, saturating at 255.

## Operation

- States: IDLE, SERVE, RALLY, POINT, OVER.
- Frame counter `fcnt`, 8 bits:
  - Cleared on every state entry.
  - Incremented only on frame_tick.
  - A frame_tick in the entry cycle itself is not counted.
- IDLE
  - phys_step = 0.
  - Rising edge of start_btn: match_clr_n = 0 for one cycle, serve_side ← 1, go to SERVE.
- SERVE
  - phys_step = 0.
  - Touch counters, rally_len and last-side are cleared.
  - When fcnt reaches SERVE_FRAMES: go to RALLY.
- RALLY
  - phys_step = frame_tick, combinational.
  - Each cover rising edge is one touch for that side:
    - Same side as last toucher: counter increments.
    - Other side: counter resets to 1.
    - rally_len increments either way.
  - Simultaneous P1/P2 rising edges count as P1 only.
  - Touch count reaching MAX_TOUCHES+1 pulses fault_p1 or fault_p2 and goes to POINT.
  - point_evt goes to POINT. point_evt takes priority over a fault in the same cycle, and that fault is suppressed.
- POINT
  - phys_step = 0.
  - In the entry cycle, serve_side latches the scorer:
    - On point_evt: the side whose score changed. Scores are sampled one cycle after point_evt, when they are settled.
    - On a fault: the non-faulting side.
  - When fcnt reaches PAUSE_FRAMES:
    - If either score ≥ WIN_SCORE: winner is set (P1 wins ties), go to OVER.
    - Otherwise go to SERVE.
- OVER
  - phys_step = 0; winner is held.
  - Rising edge of start_btn: match_clr_n pulse, winner ← 00, serve_side ← 1, go to SERVE.
- Ignored inputs:
  - start_btn outside IDLE/OVER.
  - point_evt and cover edges outside RALLY.
- Edge detection uses registered previous values. Previous values reset to 1, so a button or cover already high at reset produces no edge.

## Timing

- Reset values: state = IDLE, phys_step = 0, match_clr_n = 1, fault_* = 0, serve_side = 1, winner = 00, rally_len = 0, all counters 0.
- Input edge to state change: 1 cycle.
- match_clr_n is low during exactly the cycle after the start edge; SERVE is entered on the same edge.
- Fault pulse: the registered output goes high on the edge that enters POINT.
- An asynchronous reset mid-rally forces IDLE immediately with phys_step = 0. Physics is cleared by its own rst_n.
- The frame counter never wraps because parameters are ≤ 255. Values above 255 are a configuration error.

## Structure

- Shared package `game_pkg`:
  - State enum.
  - Side encoding (SIDE_P1 = 0, SIDE_P2 = 1).
  - Winner encoding.
  - SCORE_W.
- Sub-module `rise_detect`: one-bit registered edge detector with reset-to-1. It is instantiated for start_btn, p1_cover and p2_cover.
- Touch counters: two 3-bit counters plus a last-side flag, inline.

## Test plan

- Reset, then start_btn rises: one-cycle match_clr_n low, SERVE. After 30 frame_ticks, RALLY; phys_step mirrors frame_tick.
- point_evt with p2_score 0→1: POINT, serve_side = 1, phys_step = 0 for 60 frames, then SERVE.
- p1_cover pulsed 4 times with no P2 touch: fault_p1 pulses on the 4th, serve_side = 1, rally_len = 4. Interleaving a p2_cover after 3 P1 touches: no fault.
- p1_score reaches 7 on point_evt: after 60 frames, OVER with winner = 01. start_btn returns to SERVE and winner = 00.
- Fault edge and point_evt in the same cycle: no fault pulse, POINT via point_evt. p1_cover and p2_cover rise together: only the P1 count advances.
- rst_n asserted mid-RALLY: immediate IDLE, all outputs at reset values. start_btn held high through reset release: no start until it falls and rises again.
